instr_decode: RTL
=================

INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and instruction width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_ir input XLEN, in_pc input XLEN: fetched instruction and its PC.
REQ-006 SHALL have ports flush input 1: discard the held and incoming instruction.
REQ-007 SHALL have ports wb_en input 1, wb_addr input 5, wb_data input XLEN: register-file write port.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: downstream handshake.
REQ-009 SHALL have outputs out_pc XLEN, out_opcode 6, out_funct 6, out_shamt 5, out_rs_val XLEN, out_rt_val XLEN, out_imm XLEN, out_dest 5, out_reg_write 1, out_is_load 1, out_is_store 1, out_is_branch 1, out_is_jump 1, out_illegal 1.
REQ-010 SHALL have output stall_cnt 16: count of back-pressure cycles.

Function
REQ-011 Fields SHALL be: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0].
REQ-012 Legal opcodes SHALL be 0x00 R-type, 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x05 BNE, 0x02 J; any other opcode SHALL set out_illegal=1, all other control flags 0.
REQ-013 out_imm SHALL be sign-extended imm[15:0] for ADDI/LW/SW/BEQ/BNE; zero-extended ir[25:0] for J; 0 for R-type.
REQ-014 out_dest SHALL be rd for R-type, rt for ADDI/LW, 0 otherwise; out_reg_write SHALL be 1 only when out_dest != 0.
REQ-015 One-entry output register; in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-016 Transfer in SHALL occur when in_valid && in_ready; decoded fields and register operands SHALL be captured at that edge, out_valid=1 next cycle (latency 1).
REQ-017 When out_valid && !out_ready, all outputs SHALL hold stable and stall_cnt SHALL increment, saturating at 0xFFFF.
REQ-018 Output consumed with no new transfer in SHALL clear out_valid next cycle.
REQ-019 flush SHALL clear out_valid next cycle and drop any coincident input; flush overrides accept.
REQ-020 Register file: NREG x XLEN, two combinational read ports indexed by rs/rt, write on edge when wb_en && wb_addr != 0; register 0 SHALL always read 0.
REQ-021 Operands held in the output register SHALL NOT be updated by later write-backs.

Reset
REQ-022 reset SHALL asynchronously clear out_valid, every out_* field, stall_cnt and all registers of the register file to 0.
REQ-023 reset asserted mid-stall SHALL discard the held instruction; in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-024 Macro ID_WB_BYPASS_EN defined: on a transfer-in edge with wb_en && wb_addr == rs (or rt) && addr != 0, the captured operand SHALL be wb_data.
REQ-025 Macro ID_WB_BYPASS_EN undefined: the captured operand SHALL be the pre-write register value; no bypass logic is present.

Structure
REQ-026 Opcode constants, field bit positions and the decoded-instruction struct typedef SHALL live in shared package bubble_pkg.
REQ-027 The register file SHALL be sub-module reg_file (two read, one write port); decode and handshake logic stay in instr_decode.

Verification
REQ-028 reset, then in_ir=0x20A5_0007 (ADDI r5,r5,7), in_pc=0x10 -> next cycle out_valid=1, out_dest=5, out_imm=0x7, out_reg_write=1, out_pc=0x10.
REQ-029 wb r3=0xDEAD_BEEF, then LW r4,-4(r3) (0x8C64_FFFC) -> out_rs_val=0xDEAD_BEEF, out_imm=0xFFFF_FFFC, out_is_load=1, out_dest=4.
REQ-030 out_ready=0 for 5 cycles with instruction held -> outputs unchanged, in_ready=0, stall_cnt=5; out_ready=1 -> out_valid=0 next cycle if no input.
REQ-031 flush and in_valid in the same cycle with out_valid=1 -> out_valid=0 next cycle, incoming instruction never appears.
REQ-032 wb_en to r7=0x55 on the same edge as accepting ADD using rs=7 -> out_rs_val=0x55 with ID_WB_BYPASS_EN, old value (0 after reset) without.
REQ-033 opcode 0x3F -> out_illegal=1, out_reg_write=0; write to r0 with 0x1234 -> r0 still reads 0.

Source files
------------

// File: rtl/bubble_pkg.sv
// +-------------------------------------------------------------------------+
// | bubble_pkg : opcode constants, field positions and decoded-instr struct |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
`default_nettype none

package bubble_pkg;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_j     = 6'h02;

  localparam int c_opcode_lsb = 26;
  localparam int c_rs_lsb     = 21;
  localparam int c_rt_lsb     = 16;
  localparam int c_rd_lsb     = 11;
  localparam int c_shamt_lsb  = 6;
  localparam int c_funct_lsb  = 0;

  typedef enum logic [1:0] {
    IMM_NONE   = 2'd0,
    IMM_SEXT16 = 2'd1,
    IMM_ZEXT26 = 2'd2
  } imm_sel_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    imm_sel_e   imm_sel;
    logic       reg_write;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       illegal;
  } decoded_t;

  function automatic decoded_t decode_ir(input logic [31:0] ir);
    decoded_t d;
    d        = '0;
    d.opcode = ir[c_opcode_lsb +: 6];
    d.funct  = ir[c_funct_lsb +: 6];
    d.shamt  = ir[c_shamt_lsb +: 5];
    d.rs     = ir[c_rs_lsb +: 5];
    d.rt     = ir[c_rt_lsb +: 5];
    case (d.opcode)
      c_op_rtype: d.dest = ir[c_rd_lsb +: 5];
      c_op_addi: begin
        d.dest    = ir[c_rt_lsb +: 5];
        d.imm_sel = IMM_SEXT16;
      end
      c_op_lw: begin
        d.dest    = ir[c_rt_lsb +: 5];
        d.imm_sel = IMM_SEXT16;
        d.is_load = 1'b1;
      end
      c_op_sw: begin
        d.imm_sel  = IMM_SEXT16;
        d.is_store = 1'b1;
      end
      c_op_beq, c_op_bne: begin
        d.imm_sel   = IMM_SEXT16;
        d.is_branch = 1'b1;
      end
      c_op_j: begin
        d.imm_sel = IMM_ZEXT26;
        d.is_jump = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    d.reg_write = (d.dest != 5'd0);
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// +-------------------------------------------------------------------------+
// | reg_file : NREG x XLEN register file, two async read, one write port    |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs_addr,
  input  logic [4:0]      rt_addr,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] rt_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] r_mem [NREG];

  // Register 0 is never written, so it stays at its reset value of zero.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0 || 32'(addr) >= NREG) begin
      return '0;
    end
    return r_mem[addr[AW-1:0]];
  endfunction

  assign rs_data = read_port(rs_addr);
  assign rt_data = read_port(rt_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wb_en && wb_addr != 5'd0 && 32'(wb_addr) < NREG) begin
      r_mem[wb_addr[AW-1:0]] <= wb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_decode.sv
// +-------------------------------------------------------------------------+
// | instr_decode : decode stage with one-entry output register and regfile  |
// | Option       : ID_WB_BYPASS_EN forwards same-edge write-back to operands|
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
`default_nettype none

module instr_decode
  import bubble_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_ir,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [5:0]      out_opcode,
  output logic [5:0]      out_funct,
  output logic [4:0]      out_shamt,
  output logic [XLEN-1:0] out_rs_val,
  output logic [XLEN-1:0] out_rt_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_dest,
  output logic            out_reg_write,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_illegal,
  output logic [15:0]     stall_cnt
);

  decoded_t        w_dec;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs_rf;
  logic [XLEN-1:0] w_rt_rf;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic            w_accept;

  assign w_dec = decode_ir(in_ir[31:0]);

  always_comb begin
    w_imm = '0;
    case (w_dec.imm_sel)
      IMM_SEXT16: w_imm = {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};
      IMM_ZEXT26: w_imm = {{(XLEN-26){1'b0}}, in_ir[25:0]};
      default:    w_imm = '0;
    endcase
  end

  reg_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (w_dec.rs),
    .rt_addr (w_dec.rt),
    .rs_data (w_rs_rf),
    .rt_data (w_rt_rf),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

`ifdef ID_WB_BYPASS_EN
  assign w_rs_val = (wb_en && wb_addr != 5'd0 && wb_addr == w_dec.rs) ? wb_data : w_rs_rf;
  assign w_rt_val = (wb_en && wb_addr != 5'd0 && wb_addr == w_dec.rt) ? wb_data : w_rt_rf;
`else
  assign w_rs_val = w_rs_rf;
  assign w_rt_val = w_rt_rf;
`endif

  // Flush blocks acceptance so the coincident instruction is dropped.
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_opcode    <= '0;
      out_funct     <= '0;
      out_shamt     <= '0;
      out_rs_val    <= '0;
      out_rt_val    <= '0;
      out_imm       <= '0;
      out_dest      <= '0;
      out_reg_write <= 1'b0;
      out_is_load   <= 1'b0;
      out_is_store  <= 1'b0;
      out_is_branch <= 1'b0;
      out_is_jump   <= 1'b0;
      out_illegal   <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (w_accept) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_opcode    <= w_dec.opcode;
        out_funct     <= w_dec.funct;
        out_shamt     <= w_dec.shamt;
        out_rs_val    <= w_rs_val;
        out_rt_val    <= w_rt_val;
        out_imm       <= w_imm;
        out_dest      <= w_dec.dest;
        out_reg_write <= w_dec.reg_write;
        out_is_load   <= w_dec.is_load;
        out_is_store  <= w_dec.is_store;
        out_is_branch <= w_dec.is_branch;
        out_is_jump   <= w_dec.is_jump;
        out_illegal   <= w_dec.illegal;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
